// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM controller and the host-side
// arbiter.
//   BANK_W / ROW_W / COL_W : host address field widths
//   HADDR_W                : host byte-address width (bank+row+col)
//   arb_state_t            : arbiter FSM state encoding
package sdram_pkg;

    localparam int BANK_W  = 2;
    localparam int ROW_W   = 13;
    localparam int COL_W   = 10;
    localparam int HADDR_W = BANK_W + ROW_W + COL_W;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req   : request vector, one bit per port
//   ptr   : highest-priority port index (must be < NUM_PORTS)
//   grant : first requesting port at or after ptr, wrapping
//   found : at least one request present
module rr_select #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    grant,
    output logic                 found
);

    logic [2*NUM_PORTS-1:0] rot;

    always_comb begin
        // Bit k of the rotated vector is port (ptr+k) mod NUM_PORTS.
        rot   = {req, req} >> ptr;
        grant = '0;
        found = 1'b0;
        // Scan farthest-first so the port nearest ptr overwrites the rest.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant = (int'(ptr) + k >= NUM_PORTS) ? PORT_W'(int'(ptr) + k - NUM_PORTS)
                                                     : PORT_W'(int'(ptr) + k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin share of the single-port SDRAM controller
// host interface among NUM_PORTS requesters, one transaction in flight.
//   req_*        : per-port request (valid/we/addr/wdata), held until req_ready
//   req_ready    : one-hot pulse in the cycle the controller acks the request
//   rsp_*        : one-hot read response pulse, rsp_err marks a watchdog abort
//   sdram_*      : controller host interface (enables held until ack)
//   arb_busy     : high whenever a transaction is in progress
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int HADDR_WIDTH = HADDR_W,
    parameter int PORT_W      = 2,
    parameter int RD_TIMEOUT  = 63
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*8-1:0]           req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic                             rsp_err,
    output logic [7:0]                       rsp_data,
    output logic [HADDR_WIDTH-1:0]           sdram_wr_addr,
    output logic [7:0]                       sdram_wr_data,
    output logic                             sdram_wr_enable,
    output logic [HADDR_WIDTH-1:0]           sdram_rd_addr,
    output logic                             sdram_rd_enable,
    input  logic                             sdram_ack,
    input  logic                             sdram_rd_ready,
    input  logic [7:0]                       sdram_rd_data,
    output logic                             arb_busy
);

    localparam int WD_W = $clog2(RD_TIMEOUT + 1);

    arb_state_t             state;
    logic [PORT_W-1:0]      rr_ptr;
    logic [PORT_W-1:0]      grant_r;
    logic                   we_r;
    logic [HADDR_WIDTH-1:0] addr_r;
    logic [7:0]             wdata_r;
    logic [WD_W-1:0]        wd;

    logic [PORT_W-1:0]      sel;
    logic                   found;
    logic                   sel_we;
    logic [HADDR_WIDTH-1:0] sel_addr;
    logic [7:0]             sel_wdata;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] idx);
        return (idx == PORT_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_select (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (sel),
        .found (found)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == PORT_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*HADDR_WIDTH +: HADDR_WIDTH];
                sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // req_ready must coincide with the ack cycle: a registered pulse would
    // arrive while the requester still holds req_valid and cause a re-grant.
    assign req_ready     = (state == ISSUE && sdram_ack) ? port_onehot(grant_r) : '0;
    assign arb_busy      = (state != ARB);
    assign sdram_wr_addr = addr_r;
    assign sdram_rd_addr = addr_r;
    assign sdram_wr_data = wdata_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ARB;
            rr_ptr          <= '0;
            grant_r         <= '0;
            we_r            <= 1'b0;
            addr_r          <= '0;
            wdata_r         <= '0;
            wd              <= '0;
            sdram_wr_enable <= 1'b0;
            sdram_rd_enable <= 1'b0;
            rsp_valid       <= '0;
            rsp_err         <= 1'b0;
            rsp_data        <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ARB: begin
                    if (found) begin
                        grant_r         <= sel;
                        we_r            <= sel_we;
                        addr_r          <= sel_addr;
                        wdata_r         <= sel_wdata;
                        sdram_wr_enable <= sel_we;
                        sdram_rd_enable <= ~sel_we;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ack may be stretched by refresh; keep the enable up until it comes.
                    if (sdram_ack) begin
                        sdram_wr_enable <= 1'b0;
                        sdram_rd_enable <= 1'b0;
                        rr_ptr          <= next_port(grant_r);
                        wd              <= '0;
                        state           <= we_r ? ARB : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // rd_ready takes priority over a watchdog expiring in the same cycle.
                    if (sdram_rd_ready) begin
                        rsp_data  <= sdram_rd_data;
                        rsp_valid <= port_onehot(grant_r);
                        state     <= ARB;
                    end else if (wd == WD_W'(RD_TIMEOUT)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= port_onehot(grant_r);
                        state     <= ARB;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized bench for sdram_arbiter with a behavioural
// requester/controller model and a round-robin reference (pending set + pointer).
module tb_sdram_arbiter;

    localparam int NP = 2;
    localparam int AW = 25;
    localparam int PW = 2;
    localparam int TO = 63;

    logic           clk = 1'b0;
    logic           rst;
    logic [NP-1:0]  req_valid;
    logic [NP-1:0]  req_we;
    logic [NP*AW-1:0] req_addr;
    logic [NP*8-1:0]  req_wdata;
    logic [NP-1:0]  req_ready;
    logic [NP-1:0]  rsp_valid;
    logic           rsp_err;
    logic [7:0]     rsp_data;
    logic [AW-1:0]  sdram_wr_addr;
    logic [7:0]     sdram_wr_data;
    logic           sdram_wr_enable;
    logic [AW-1:0]  sdram_rd_addr;
    logic           sdram_rd_enable;
    logic           sdram_ack;
    logic           sdram_rd_ready;
    logic [7:0]     sdram_rd_data;
    logic           arb_busy;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .NUM_PORTS   (NP),
        .HADDR_WIDTH (AW),
        .PORT_W      (PW),
        .RD_TIMEOUT  (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_err         (rsp_err),
        .rsp_data        (rsp_data),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_data   (sdram_wr_data),
        .sdram_wr_enable (sdram_wr_enable),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_enable (sdram_rd_enable),
        .sdram_ack       (sdram_ack),
        .sdram_rd_ready  (sdram_rd_ready),
        .sdram_rd_data   (sdram_rd_data),
        .arb_busy        (arb_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending requests per port and round-robin pointer.
    bit          p_vld  [NP];
    bit          p_we   [NP];
    logic [AW-1:0] p_addr [NP];
    logic [7:0]  p_data [NP];
    int          ref_ptr;
    logic [7:0]  last_rsp;
    int          grants[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic int ref_pick();
        for (int k = 0; k < NP; k++)
            if (p_vld[(ref_ptr + k) % NP]) return (ref_ptr + k) % NP;
        return -1;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NP; i++) begin
            req_valid[i]            = p_vld[i];
            req_we[i]               = p_we[i];
            req_addr[i*AW +: AW]    = p_addr[i];
            req_wdata[i*8 +: 8]     = p_data[i];
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [7:0] d);
        p_vld[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
    endtask

    task automatic set_rand(input int p);
        set_req(p, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NP; i++) p_vld[i] = 1'b0;
        drive_req();
    endtask

    // One transaction from the current pending set. rd_dly = 0 means the
    // controller never returns rd_ready. Called and returns at a negedge.
    task automatic do_txn(input int ack_dly, input int rd_dly, input logic [7:0] rbyte, input bit refill);
        int ep, got;
        bit seen, done, ep_we;
        ep = ref_pick();
        ep_we = p_we[ep];
        got = -1;
        drive_req();
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (sdram_wr_enable | sdram_rd_enable) seen = 1'b1;
        end
        if (!seen) begin
            check("enable_timeout", 0, 1);
            return;
        end
        for (int k = 1; k <= ack_dly; k++) begin
            if (k > 1) @(negedge clk);
            check("en_overlap", 32'(sdram_wr_enable & sdram_rd_enable), 0);
            check("busy_issue", 32'(arb_busy), 1);
            check("wr_en", 32'(sdram_wr_enable), 32'(p_we[ep]));
            check("rd_en", 32'(sdram_rd_enable), 32'(!p_we[ep]));
            check("wr_addr", 32'(sdram_wr_addr), 32'(p_addr[ep]));
            check("rd_addr", 32'(sdram_rd_addr), 32'(p_addr[ep]));
            check("wr_data", 32'(sdram_wr_data), 32'(p_data[ep]));
            check("rsp_quiet", 32'(rsp_valid), 0);
            check("rsp_data_hold", 32'(rsp_data), 32'(last_rsp));
            if (k == ack_dly) sdram_ack = 1'b1;
            #1;
            check("req_ready", 32'(req_ready), (k == ack_dly) ? 32'(onehot(ep)) : 0);
            if (k == ack_dly)
                for (int i = 0; i < NP; i++) if (req_ready[i]) got = i;
        end
        grants.push_back(got);
        @(negedge clk);
        sdram_ack = 1'b0;
        check("en_after_ack", {30'b0, sdram_wr_enable, sdram_rd_enable}, 0);
        check("ready_after_ack", 32'(req_ready), 0);
        ref_ptr = (ep + 1) % NP;
        if (refill) set_rand(ep);
        else p_vld[ep] = 1'b0;
        drive_req();
        if (ep_we) begin
            check("busy_after_wr", 32'(arb_busy), 0);
        end else if (rd_dly > 0) begin
            for (int c = 1; c <= rd_dly + 1; c++) begin
                if (c > 1) @(negedge clk);
                if (c <= rd_dly) begin
                    check("rsp_early", 32'(rsp_valid), 0);
                    check("busy_wait", 32'(arb_busy), 1);
                end
                if (c == rd_dly) begin
                    sdram_rd_ready = 1'b1;
                    sdram_rd_data  = rbyte;
                end
                if (c == rd_dly + 1) begin
                    sdram_rd_ready = 1'b0;
                    check("rsp_valid", 32'(rsp_valid), 32'(onehot(ep)));
                    check("rsp_err", 32'(rsp_err), 0);
                    check("rsp_data", 32'(rsp_data), 32'(rbyte));
                    last_rsp = rbyte;
                end
            end
        end else begin
            done = 1'b0;
            for (int c = 1; c <= TO + 4 && !done; c++) begin
                if (c > 1) @(negedge clk);
                if (rsp_valid != '0) begin
                    done = 1'b1;
                    check("abort_latency", 32'(c >= TO + 1 && c <= TO + 2), 1);
                    check("abort_valid", 32'(rsp_valid), 32'(onehot(ep)));
                    check("abort_err", 32'(rsp_err), 1);
                    check("abort_data", 32'(rsp_data), 0);
                    last_rsp = 8'h00;
                end
            end
            if (!done) check("abort_timeout", 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int ack, rd;
        rst = 1'b1;
        sdram_ack = 1'b0; sdram_rd_ready = 1'b0; sdram_rd_data = '0;
        for (int i = 0; i < NP; i++) begin
            p_vld[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        drive_req();
        ref_ptr = 0;
        last_rsp = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(arb_busy), 0);
        check("rst_en", {30'b0, sdram_wr_enable, sdram_rd_enable}, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        check("rst_addr", 32'(sdram_wr_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Port0 write, ack in the first enable cycle.
        set_req(0, 1'b1, 25'h0012345, 8'h5A);
        do_txn(1, 0, 8'h00, 1'b0);

        // Port1 read, data returned 4 cycles after ack.
        set_req(1, 1'b0, 25'h1000003, 8'h00);
        do_txn(1, 4, 8'hA5, 1'b0);

        // Both ports asserting continuously: grants must alternate from port 0.
        grants.delete();
        set_rand(0);
        set_rand(1);
        for (int t = 0; t < 4; t++)
            do_txn($urandom_range(1, 3), $urandom_range(1, 8), 8'($urandom), 1'b1);
        for (int t = 0; t < 4; t++)
            check("rr_order", 32'(grants[t]), 32'(t % 2));
        clear_reqs();

        // Ack held off by refresh for 12 cycles.
        set_req(1, 1'b1, AW'($urandom), 8'($urandom));
        do_txn(12, 0, 8'h00, 1'b0);

        // Random traffic.
        for (int t = 0; t < 20; t++) begin
            for (int p = 0; p < NP; p++)
                if (!p_vld[p] && $urandom_range(0, 1) == 1) set_rand(p);
            if (ref_pick() < 0) set_rand($urandom_range(0, NP - 1));
            ack = $urandom_range(1, 4);
            rd  = ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(1, 10);
            do_txn(ack, rd, 8'($urandom), 1'b0);
        end
        clear_reqs();

        // rd_ready in the same cycle the watchdog expires: data wins.
        set_req(1, 1'b0, AW'($urandom), 8'h00);
        do_txn(2, TO + 1, 8'h3C, 1'b0);

        // Port0 read that never completes, then a stray rd_ready.
        set_req(0, 1'b0, AW'($urandom), 8'h00);
        do_txn(1, 0, 8'h00, 1'b0);
        @(negedge clk);
        sdram_rd_ready = 1'b1; sdram_rd_data = 8'hEE;
        @(negedge clk);
        sdram_rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stray_rsp", 32'(rsp_valid), 0);
            @(negedge clk);
        end

        // Reset while waiting for read data on port 0.
        set_req(0, 1'b0, AW'($urandom), 8'h11);
        drive_req();
        @(negedge clk);
        check("pre_rst_en", 32'(sdram_rd_enable), 1);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        p_vld[0] = 1'b0;
        drive_req();
        check("pre_rst_busy", 32'(arb_busy), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(arb_busy), 0);
        check("arst_en", {30'b0, sdram_wr_enable, sdram_rd_enable}, 0);
        check("arst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        check("arst_ready", 32'(req_ready), 0);
        check("arst_addr", 32'(sdram_rd_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = 0;
        last_rsp = 8'h00;
        sdram_rd_ready = 1'b1; sdram_rd_data = 8'h77;
        @(negedge clk);
        sdram_rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("post_rst_rsp", 32'(rsp_valid), 0);
            @(negedge clk);
        end
        grants.delete();
        set_req(0, 1'b1, AW'($urandom), 8'($urandom));
        set_req(1, 1'b1, AW'($urandom), 8'($urandom));
        do_txn(1, 0, 8'h00, 1'b0);
        check("post_rst_grant", 32'(grants[0]), 0);
        clear_reqs();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single-port 8-bit SDRAM controller between NUM_PORTS host requesters using round-robin arbitration. It keeps at most one transaction in flight. It holds the controller's wr_enable/rd_enable until ack, then routes returned read data to the owning port. A read watchdog flags reads that never complete. It sits between the host-side masters (CPU bridge, video fetch, etc.) and the SDRAM controller's host interface.

Parameters:
NUM_PORTS, 2, number of requesters (2..4)
HADDR_WIDTH, 25, host byte-address width (bank+row+col), matches the controller
PORT_W, 2, width of the grant index; must satisfy 2**PORT_W >= NUM_PORTS
RD_TIMEOUT, 63, cycles to wait for sdram_rd_ready after read ack before aborting

Ports:
clk  in  1  system clock, same clock as the SDRAM controller
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_PORTS  per-port request; held with addr/data/we until req_ready
req_we  in  NUM_PORTS  per-port 1=write, 0=read
req_addr  in  NUM_PORTS*HADDR_WIDTH  packed per-port address, port i at [i*HADDR_WIDTH +: HADDR_WIDTH]
req_wdata  in  NUM_PORTS*8  packed per-port write byte
req_ready  out  NUM_PORTS  one-hot 1-cycle pulse: request accepted by the controller
rsp_valid  out  NUM_PORTS  one-hot 1-cycle pulse: read data or abort for that port
rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort, rsp_data=0
rsp_data  out  8  read byte, shared by all ports
sdram_wr_addr  out  HADDR_WIDTH  to controller wr_addr
sdram_wr_data  out  8  to controller wr_data
sdram_wr_enable  out  1  to controller wr_enable
sdram_rd_addr  out  HADDR_WIDTH  to controller rd_addr
sdram_rd_enable  out  1  to controller rd_enable
sdram_ack  in  1  controller ack, 1-cycle pulse
sdram_rd_ready  in  1  controller rd_ready, one cycle high per read
sdram_rd_data  in  8  controller rd_data
arb_busy  out  1  high in any state but ARB

Behaviour:
- Reset (async): state=ARB, rr_ptr=0, all outputs 0, latched addr/data=0, watchdog=0.
- States: ARB, ISSUE, WAIT_RD.
- ARB:
  - If any req_valid, select the first requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Latch grant index, we, addr and wdata into registers, then go to ISSUE.
  - No request: remain in ARB.
- ISSUE: drive registered sdram_wr_enable=we or sdram_rd_enable=~we, never both.
  - Drive the latched address on both sdram_wr_addr and sdram_rd_addr, and the latched byte on sdram_wr_data.
  - Hold until sdram_ack is sampled high. The enable must be low in the cycle after ack. The controller has already left IDLE, so this causes no double issue.
  - On ack: req_ready[grant] pulses for that cycle, and rr_ptr becomes (grant+1) mod NUM_PORTS.
  - On ack for a write, go to ARB. On ack for a read, go to WAIT_RD with watchdog=0.
  - An ack delayed by refresh is legal. There is no timeout in ISSUE.
- WAIT_RD:
  - Increment the watchdog each cycle.
  - On sdram_rd_ready: register rsp_data=sdram_rd_data and pulse rsp_valid[grant] one cycle later with rsp_err=0, then go to ARB.
  - If the watchdog reaches RD_TIMEOUT with no rd_ready: pulse rsp_valid[grant] with rsp_err=1 and rsp_data=0, then go to ARB.
  - If rd_ready and timeout coincide, rd_ready wins.
- Minimum cost: ARB→ISSUE takes 1 cycle. The controller adds 1 cycle to ack.
- A late sdram_rd_ready arriving in ARB/ISSUE after an abort is ignored.
- A port's req_valid dropping before req_ready is a protocol violation; behaviour is not defined.
- rst mid-transaction: the in-flight response is dropped, and no req_ready or rsp_valid is emitted.
- rsp_data holds its last value between pulses.

Decomposition:
- Shared package sdram_pkg holds HADDR_WIDTH/ROW/COL/BANK widths and the arbiter state encoding constants, shared with the SDRAM controller.
- One sub-module, rr_select (combinational: request vector + pointer → grant index + found), is natural and reusable.

Test Plan:
- Port0 write addr 0x0012345, data 0x5A, with an ack model 1 cycle after enable → sdram_wr_enable high exactly 1 cycle, req_ready=01 once, arb_busy back low 1 cycle later.
- Port1 read addr 0x1000003; model returns rd_ready with 0xA5 4 cycles after ack → rsp_valid=10, rsp_data=0xA5, rsp_err=0; sdram_rd_enable never overlaps sdram_wr_enable.
- Both ports assert continuously, 4 transactions → grant order 0,1,0,1; no starvation; at most one enable high at a time.
- Model delays ack 12 cycles (refresh) → enable held 12 cycles with stable addr/data; single req_ready.
- Port0 read, model never asserts rd_ready → rsp_valid=01 with rsp_err=1, rsp_data=0 after RD_TIMEOUT cycles; a later stray rd_ready produces no pulse.
- rst asserted in WAIT_RD → outputs zero immediately (async); after release, no rsp_valid; the next request is granted starting from port 0.
